// File: rtl/ft_alu_pkg.sv
// Shared definitions for the fault-tolerant ALU and its retry front end:
// opcode encodings, controller states and bit positions of status vectors.
package ft_alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_INC  = 4'h2;
  localparam logic [3:0] OP_DEC  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_NOT  = 4'h7;
  localparam logic [3:0] OP_SHL  = 4'h8;
  localparam logic [3:0] OP_SHR  = 4'h9;
  localparam logic [3:0] OP_PASS = 4'hA;
  localparam logic [3:0] OP_ZERO = 4'hB;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_CHECK = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Bit positions inside err_seen / rsp_err_seen
  localparam int ERR_PARITY = 0;
  localparam int ERR_RES3   = 1;
  localparam int ERR_RES5   = 2;
  localparam int ERR_CARRY  = 3;

  // Bit positions inside rsp_flags
  localparam int FLAG_COUT = 0;
  localparam int FLAG_ZERO = 1;
  localparam int FLAG_OVF  = 2;

endpackage

// File: rtl/ft_alu_retry_controller_sat_counter.sv
// Saturating event counter; a clear wins over a same-cycle increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/ft_alu_retry_controller.sv
// Request/response front end for the fault-tolerant ALU: issues an operation,
// re-issues it while the ALU flags an error, and keeps error statistics.
module ft_alu_retry_controller
  import ft_alu_pkg::*;
#(
  parameter int MAX_RETRY = 3,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [15:0]      req_a,
  input  logic [15:0]      req_b,
  input  logic [3:0]       req_op,
  output logic [15:0]      alu_operand_a,
  output logic [15:0]      alu_operand_b,
  output logic [3:0]       alu_opcode,
  input  logic [15:0]      alu_result,
  input  logic             alu_cout,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  input  logic             alu_parity_err,
  input  logic             alu_residue3_err,
  input  logic             alu_residue5_err,
  input  logic             alu_carry_err,
  input  logic             alu_error,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [15:0]      rsp_result,
  output logic [2:0]       rsp_flags,
  output logic [3:0]       rsp_err_seen,
  output logic [3:0]       rsp_retries,
  output logic             rsp_fault,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] cnt_parity,
  output logic [CNT_W-1:0] cnt_res3,
  output logic [CNT_W-1:0] cnt_res5,
  output logic [CNT_W-1:0] cnt_carry,
  output logic [CNT_W-1:0] cnt_retry,
  output logic [CNT_W-1:0] cnt_fault
);

  localparam logic [3:0] MAX_R = 4'(MAX_RETRY);

  state_e      state_q, state_d;
  logic [15:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [3:0]  opcode_q, opcode_d;
  logic [3:0]  retries_q, retries_d;
  logic [3:0]  err_seen_q, err_seen_d;
  logic [15:0] rsp_result_q, rsp_result_d;
  logic [2:0]  rsp_flags_q, rsp_flags_d;
  logic [3:0]  rsp_err_seen_q, rsp_err_seen_d;
  logic [3:0]  rsp_retries_q, rsp_retries_d;
  logic        rsp_fault_q, rsp_fault_d;

  logic [3:0]  cur_err_s;
  logic        in_check_s, can_retry_s, inc_retry_s, inc_fault_s;

  always_comb begin
    cur_err_s             = 4'b0000;
    cur_err_s[ERR_PARITY] = alu_parity_err;
    cur_err_s[ERR_RES3]   = alu_residue3_err;
    cur_err_s[ERR_RES5]   = alu_residue5_err;
    cur_err_s[ERR_CARRY]  = alu_carry_err;
  end

  assign in_check_s  = (state_q == ST_CHECK);
  assign can_retry_s = (retries_q < MAX_R);
  assign inc_retry_s = in_check_s && alu_error && can_retry_s;
  assign inc_fault_s = in_check_s && alu_error && !can_retry_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = req_valid ? ST_ISSUE : ST_IDLE;
      ST_ISSUE: state_d = ST_CHECK;
      ST_CHECK: state_d = (alu_error && can_retry_s) ? ST_ISSUE : ST_RESP;
      ST_RESP:  state_d = rsp_ready ? ST_IDLE : ST_RESP;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == ST_IDLE);
    rsp_valid = (state_q == ST_RESP);
  end

  // Operand/response datapath; operands stay put across re-issues
  always_comb begin
    op_a_d         = op_a_q;
    op_b_d         = op_b_q;
    opcode_d       = opcode_q;
    retries_d      = retries_q;
    err_seen_d     = err_seen_q;
    rsp_result_d   = rsp_result_q;
    rsp_flags_d    = rsp_flags_q;
    rsp_err_seen_d = rsp_err_seen_q;
    rsp_retries_d  = rsp_retries_q;
    rsp_fault_d    = rsp_fault_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_a_d     = req_a;
          op_b_d     = req_b;
          opcode_d   = req_op;
          retries_d  = 4'd0;
          err_seen_d = 4'b0000;
        end else begin
          opcode_d = OP_ZERO;
        end
      end
      ST_CHECK: begin
        err_seen_d = err_seen_q | cur_err_s;
        if (inc_retry_s) begin
          retries_d = retries_q + 4'd1;
        end else begin
          rsp_result_d           = alu_result;
          rsp_flags_d[FLAG_OVF]  = alu_overflow;
          rsp_flags_d[FLAG_ZERO] = alu_zero;
          rsp_flags_d[FLAG_COUT] = alu_cout;
          rsp_err_seen_d         = err_seen_q | cur_err_s;
          rsp_retries_d          = retries_q;
          rsp_fault_d            = alu_error;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          opcode_d = OP_ZERO;
        end else begin
          opcode_d = opcode_q;
        end
      end
      default: begin
        opcode_d = opcode_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_q         <= 16'h0000;
      op_b_q         <= 16'h0000;
      opcode_q       <= OP_ZERO;
      retries_q      <= 4'd0;
      err_seen_q     <= 4'b0000;
      rsp_result_q   <= 16'h0000;
      rsp_flags_q    <= 3'b000;
      rsp_err_seen_q <= 4'b0000;
      rsp_retries_q  <= 4'd0;
      rsp_fault_q    <= 1'b0;
    end else begin
      op_a_q         <= op_a_d;
      op_b_q         <= op_b_d;
      opcode_q       <= opcode_d;
      retries_q      <= retries_d;
      err_seen_q     <= err_seen_d;
      rsp_result_q   <= rsp_result_d;
      rsp_flags_q    <= rsp_flags_d;
      rsp_err_seen_q <= rsp_err_seen_d;
      rsp_retries_q  <= rsp_retries_d;
      rsp_fault_q    <= rsp_fault_d;
    end
  end

  assign alu_operand_a = op_a_q;
  assign alu_operand_b = op_b_q;
  assign alu_opcode    = opcode_q;
  assign rsp_result    = rsp_result_q;
  assign rsp_flags     = rsp_flags_q;
  assign rsp_err_seen  = rsp_err_seen_q;
  assign rsp_retries   = rsp_retries_q;
  assign rsp_fault     = rsp_fault_q;

  sat_counter #(.W(CNT_W)) u_cnt_parity (.clk(clk), .rst_n(rst_n), .clr(clr_stats),
    .inc(in_check_s && alu_parity_err), .count(cnt_parity));
  sat_counter #(.W(CNT_W)) u_cnt_res3 (.clk(clk), .rst_n(rst_n), .clr(clr_stats),
    .inc(in_check_s && alu_residue3_err), .count(cnt_res3));
  sat_counter #(.W(CNT_W)) u_cnt_res5 (.clk(clk), .rst_n(rst_n), .clr(clr_stats),
    .inc(in_check_s && alu_residue5_err), .count(cnt_res5));
  sat_counter #(.W(CNT_W)) u_cnt_carry (.clk(clk), .rst_n(rst_n), .clr(clr_stats),
    .inc(in_check_s && alu_carry_err), .count(cnt_carry));
  sat_counter #(.W(CNT_W)) u_cnt_retry (.clk(clk), .rst_n(rst_n), .clr(clr_stats),
    .inc(inc_retry_s), .count(cnt_retry));
  sat_counter #(.W(CNT_W)) u_cnt_fault (.clk(clk), .rst_n(rst_n), .clr(clr_stats),
    .inc(inc_fault_s), .count(cnt_fault));

endmodule

// File: tb/tb_ft_alu_retry_controller.sv
// Directed bench: two controllers (default parameters, and MAX_RETRY=0/CNT_W=2)
// each driving a small registered ALU model with bench-controlled error flags.
module tb_ft_alu_retry_controller;
  import ft_alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_v = 1'b0;
  logic        sel = 1'b0;
  logic [15:0] req_a = 16'h0000, req_b = 16'h0000;
  logic [3:0]  req_op = 4'h0;
  logic        rsp_ready = 1'b1;
  logic        clr_stats = 1'b0;
  logic        f_par = 1'b0, f_r3 = 1'b0, f_r5 = 1'b0, f_car = 1'b0, f_err = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  int lat;

  always #5 clk = ~clk;

  // Main instance signals
  logic        req_ready, rsp_valid, rsp_fault;
  logic [15:0] alu_a, alu_b, rsp_result;
  logic [3:0]  alu_op, rsp_err_seen, rsp_retries;
  logic [2:0]  rsp_flags;
  logic [15:0] cnt_parity, cnt_res3, cnt_res5, cnt_carry, cnt_retry, cnt_fault;
  logic [17:0] alu1_q = 18'd0;

  // Second instance signals
  logic        req_ready2, rsp_valid2, rsp_fault2;
  logic [15:0] alu_a2, alu_b2, rsp_result2;
  logic [3:0]  alu_op2, rsp_err_seen2, rsp_retries2;
  logic [2:0]  rsp_flags2;
  logic [1:0]  cnt_parity2, cnt_res32, cnt_res52, cnt_carry2, cnt_retry2, cnt_fault2;
  logic [17:0] alu2_q = 18'd0;

  logic cur_rsp_valid;
  assign cur_rsp_valid = sel ? rsp_valid2 : rsp_valid;

  // {overflow, carry, result}
  function automatic logic [17:0] alu_fn(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    logic        v;
    s = 17'd0;
    v = 1'b0;
    case (op)
      OP_ADD: begin s = {1'b0, a} + {1'b0, b}; v = (a[15] == b[15]) && (s[15] != a[15]); end
      OP_SUB: begin s = {1'b0, a} - {1'b0, b}; v = (a[15] != b[15]) && (s[15] != a[15]); end
      OP_AND: s = {1'b0, a & b};
      OP_OR:  s = {1'b0, a | b};
      OP_XOR: s = {1'b0, a ^ b};
      default: s = 17'd0;
    endcase
    return {v, s};
  endfunction

  always @(posedge clk) begin
    alu1_q <= alu_fn(alu_op, alu_a, alu_b);
    alu2_q <= alu_fn(alu_op2, alu_a2, alu_b2);
  end

  ft_alu_retry_controller #(.MAX_RETRY(3), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_v && !sel), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_operand_a(alu_a), .alu_operand_b(alu_b), .alu_opcode(alu_op),
    .alu_result(alu1_q[15:0]), .alu_cout(alu1_q[16]), .alu_zero(alu1_q[15:0] == 16'h0000),
    .alu_overflow(alu1_q[17]), .alu_parity_err(f_par), .alu_residue3_err(f_r3),
    .alu_residue5_err(f_r5), .alu_carry_err(f_car), .alu_error(f_err),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .rsp_err_seen(rsp_err_seen), .rsp_retries(rsp_retries),
    .rsp_fault(rsp_fault), .clr_stats(clr_stats),
    .cnt_parity(cnt_parity), .cnt_res3(cnt_res3), .cnt_res5(cnt_res5),
    .cnt_carry(cnt_carry), .cnt_retry(cnt_retry), .cnt_fault(cnt_fault)
  );

  ft_alu_retry_controller #(.MAX_RETRY(0), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_v && sel), .req_ready(req_ready2),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_operand_a(alu_a2), .alu_operand_b(alu_b2), .alu_opcode(alu_op2),
    .alu_result(alu2_q[15:0]), .alu_cout(alu2_q[16]), .alu_zero(alu2_q[15:0] == 16'h0000),
    .alu_overflow(alu2_q[17]), .alu_parity_err(f_par), .alu_residue3_err(f_r3),
    .alu_residue5_err(f_r5), .alu_carry_err(f_car), .alu_error(f_err),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready), .rsp_result(rsp_result2),
    .rsp_flags(rsp_flags2), .rsp_err_seen(rsp_err_seen2), .rsp_retries(rsp_retries2),
    .rsp_fault(rsp_fault2), .clr_stats(clr_stats),
    .cnt_parity(cnt_parity2), .cnt_res3(cnt_res32), .cnt_res5(cnt_res52),
    .cnt_carry(cnt_carry2), .cnt_retry(cnt_retry2), .cnt_fault(cnt_fault2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept edge is the first posedge; lat counts cycles after it until rsp_valid.
  task automatic run_req(input logic s, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b, input bit once, input bit clrchk);
    sel = s; req_op = op; req_a = a; req_b = b; req_v = 1'b1;
    @(posedge clk);
    #1;
    req_v = 1'b0;
    lat = 1;
    while (!cur_rsp_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (once && lat == 3) begin
        f_par = 1'b0; f_r3 = 1'b0; f_r5 = 1'b0; f_car = 1'b0; f_err = 1'b0;
      end
      clr_stats = clrchk && (lat == 2);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("reset req_ready", req_ready, 1);
    check("reset rsp_valid", rsp_valid, 0);
    check("reset alu_opcode", alu_op, 4'hB);
    check("reset alu_operand_a", alu_a, 0);
    check("reset rsp_result", rsp_result, 0);
    check("reset cnt_fault", cnt_fault, 0);

    // 1: clean ADD
    run_req(1'b0, OP_ADD, 16'h1234, 16'h0001, 1'b0, 1'b0);
    check("t1 latency", lat, 3);
    check("t1 rsp_valid", rsp_valid, 1);
    check("t1 result", rsp_result, 16'h1235);
    check("t1 flags", rsp_flags, 3'b000);
    check("t1 retries", rsp_retries, 0);
    check("t1 fault", rsp_fault, 0);
    check("t1 err_seen", rsp_err_seen, 0);
    step();
    check("t1 req_ready after rsp", req_ready, 1);
    check("t1 opcode back to zero", alu_op, 4'hB);

    // 2: SUB with a parity error on the first attempt only
    f_par = 1'b1; f_err = 1'b1;
    run_req(1'b0, OP_SUB, 16'h0005, 16'h0007, 1'b1, 1'b0);
    check("t2 latency", lat, 5);
    check("t2 result", rsp_result, 16'hFFFE);
    check("t2 retries", rsp_retries, 1);
    check("t2 err_seen", rsp_err_seen, 4'b0001);
    check("t2 fault", rsp_fault, 0);
    check("t2 cnt_parity", cnt_parity, 1);
    check("t2 cnt_retry", cnt_retry, 1);
    step();

    // 3: stuck carry error exhausts retries
    f_car = 1'b1; f_err = 1'b1;
    run_req(1'b0, OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    check("t3 latency", lat, 9);
    check("t3 result", rsp_result, 16'h0000);
    check("t3 flags", rsp_flags, 3'b011);
    check("t3 retries", rsp_retries, 3);
    check("t3 fault", rsp_fault, 1);
    check("t3 err_seen", rsp_err_seen, 4'b1000);
    check("t3 cnt_carry", cnt_carry, 4);
    check("t3 cnt_fault", cnt_fault, 1);
    check("t3 cnt_retry", cnt_retry, 4);
    check("t3 cnt_parity", cnt_parity, 1);
    f_car = 1'b0; f_err = 1'b0;
    step();

    // Undefined opcode passes through and completes in one attempt
    run_req(1'b0, 4'hC, 16'h1111, 16'h2222, 1'b0, 1'b0);
    check("undef latency", lat, 3);
    check("undef opcode", alu_op, 4'hC);
    check("undef retries", rsp_retries, 0);
    step();

    // 4: response back-pressure with a competing request
    rsp_ready = 1'b0;
    run_req(1'b0, OP_XOR, 16'h00FF, 16'h0F0F, 1'b0, 1'b0);
    check("t4 latency", lat, 3);
    req_a = 16'hAAAA; req_b = 16'h5555; req_op = OP_ADD; req_v = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("t4 rsp_valid held", rsp_valid, 1);
      check("t4 result held", rsp_result, 16'h0FF0);
      check("t4 req_ready low", req_ready, 0);
      step();
    end
    req_v = 1'b0;
    rsp_ready = 1'b1;
    step();
    check("t4 rsp_valid dropped", rsp_valid, 0);
    check("t4 req_ready back", req_ready, 1);
    check("t4 offered req ignored", alu_a, 16'h00FF);
    check("t4 opcode zero", alu_op, 4'hB);

    // 5: reset pulse during CHECK
    req_op = OP_ADD; req_a = 16'h1111; req_b = 16'h2222; req_v = 1'b1;
    step();
    req_v = 1'b0;
    step();
    rst_n = 1'b0;
    #2;
    check("t5 rsp_valid", rsp_valid, 0);
    check("t5 req_ready", req_ready, 1);
    check("t5 alu_opcode", alu_op, 4'hB);
    check("t5 alu_operand_a", alu_a, 0);
    check("t5 rsp_result", rsp_result, 0);
    check("t5 cnt_carry", cnt_carry, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("t5 no rsp after reset", rsp_valid, 0);
    run_req(1'b0, OP_ADD, 16'h0002, 16'h0003, 1'b0, 1'b0);
    check("t5 latency", lat, 3);
    check("t5 result", rsp_result, 16'h0005);
    check("t5 fault", rsp_fault, 0);
    step();

    // 6: MAX_RETRY=0, CNT_W=2 saturation and clear priority
    f_par = 1'b1; f_err = 1'b1;
    for (int i = 0; i < 5; i++) begin
      run_req(1'b1, OP_ADD, 16'h0001, 16'h0001, 1'b0, 1'b0);
      check("t6 latency", lat, 3);
      check("t6 fault", rsp_fault2, 1);
      check("t6 retries", rsp_retries2, 0);
      step();
    end
    check("t6 cnt_parity sat", cnt_parity2, 2'd3);
    check("t6 cnt_fault sat", cnt_fault2, 2'd3);
    check("t6 cnt_retry", cnt_retry2, 2'd0);
    run_req(1'b1, OP_ADD, 16'h0001, 16'h0001, 1'b0, 1'b1);
    check("t6 cnt_parity cleared", cnt_parity2, 2'd0);
    check("t6 cnt_fault cleared", cnt_fault2, 2'd0);
    f_par = 1'b0; f_err = 1'b0;
    step();
    check("t6 rsp_valid dropped", rsp_valid2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
